serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around a single instance of the team's one-bit full_adder cell.

---
 rtl/serial_adder_if.sv | 34 +++
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake and operand/result bus of the bit-serial adder
//
// Purpose: groups the controller-facing signals of serial_adder.
// Signals:
//   start  controller -> adder  request, sampled only while the adder is idle or done
//   a, b   controller -> adder  WIDTH-bit operands, captured on an accepted start
//   cin    controller -> adder  carry-in, captured on an accepted start
//   busy   adder -> controller  high while operand bits are being streamed
//   done   adder -> controller  one-cycle pulse, sum/cout just updated
//   sum    adder -> controller  WIDTH-bit registered result
//   cout   adder -> controller  registered carry-out of the MSB
// Modports: master (controller side), slave (adder side).
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around a single one-bit full adder cell
//
// Purpose: loads two operands and a carry-in, streams them LSB-first through one
// full_adder cell (one bit per clock), closes the carry loop with a flip-flop and
// collects the sum bits into a result register. {cout,sum} = a + b + cin.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous, active-high reset
//   bus      serial_adder_if slave modport (start/a/b/cin in, busy/done/sum/cout out)
// Also contains full_adder: the combinational one-bit cell
//   i_a, i_b, i_cin in; o_sum, o_cout out.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] w_res_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;

    full_adder u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_fa_sum;
        end else begin : g_res_wn
            assign w_res_next = {w_fa_sum, r_res_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back: a start seen during the done cycle is accepted at once.
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_carry  <= bus.cin;
            r_cnt    <= '0;
            r_res_sh <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            r_carry  <= w_fa_cout;
            r_cnt    <= r_cnt + CW'(1);
            // Published result only moves here, so it stays stable through the next operation.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign bus.busy = (r_state == S_SHIFT);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.i_clk(clk), .i_reset(rst), .bus(if8));
    serial_adder #(.WIDTH(1)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));

    int n_checks = 0;
    int n_fail   = 0;

    bit       sel = 1'b0;
    logic       m_busy, m_done, m_cout;
    logic [7:0] m_sum;
    always_comb begin
        m_busy = sel ? if1.busy : if8.busy;
        m_done = sel ? if1.done : if8.done;
        m_cout = sel ? if1.cout : if8.cout;
        m_sum  = sel ? {7'b0, if1.sum} : if8.sum;
    end

    logic [7:0] prev_sum [2];

    typedef struct {
        bit         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b, input logic c);
        if (sel) begin
            if1.start = st; if1.a = a[0]; if1.b = b[0]; if1.cin = c;
        end else begin
            if8.start = st; if8.a = a; if8.b = b; if8.cin = c;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_sum, input logic exp_cout);
        int w = sel ? 1 : 8;
        int n, nb, unstable, both;
        nb = 0; unstable = 0; both = 0;
        @(negedge clk);
        drive(1'b1, a, b, c);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            if (m_busy && m_done) both++;
            if (m_done) break;
            if (m_busy) nb++;
            if (m_sum !== prev_sum[sel]) unstable++;
        end
        check("latency", n, w + 1);
        check("busy_cycles", nb, w);
        check("busy_done_overlap", both, 0);
        check("sum_stable", unstable, 0);
        check("sum", m_sum, exp_sum);
        check("cout", m_cout, exp_cout);
        prev_sum[sel] = exp_sum;
        @(negedge clk);
        check("done_pulse_width", m_done, 1'b0);
        check("sum_held", m_sum, exp_sum);
    endtask

    vec_t vecs [12];

    initial begin
        int n, cnt;
        logic [8:0] full;
        logic [7:0] ra, rb;
        logic       rc;

        vecs[0]  = '{0, 8'h35, 8'h4A, 0, 8'h7F, 0};
        vecs[1]  = '{0, 8'hFF, 8'h01, 0, 8'h00, 1};
        vecs[2]  = '{0, 8'hFF, 8'hFF, 1, 8'hFF, 1};
        vecs[3]  = '{0, 8'h00, 8'h00, 0, 8'h00, 0};
        vecs[4]  = '{0, 8'h80, 8'h80, 0, 8'h00, 1};
        vecs[5]  = '{0, 8'h0F, 8'hF0, 1, 8'h00, 1};
        vecs[6]  = '{0, 8'hAA, 8'h55, 0, 8'hFF, 0};
        vecs[7]  = '{0, 8'h12, 8'h34, 1, 8'h47, 0};
        vecs[8]  = '{1, 8'h01, 8'h01, 1, 8'h01, 1};
        vecs[9]  = '{1, 8'h01, 8'h00, 0, 8'h01, 0};
        vecs[10] = '{1, 8'h01, 8'h01, 0, 8'h00, 1};
        vecs[11] = '{1, 8'h00, 8'h00, 1, 8'h01, 0};

        prev_sum[0] = 8'h00;
        prev_sum[1] = 8'h00;
        sel = 0; drive(1'b0, 8'h00, 8'h00, 1'b0);
        sel = 1; drive(1'b0, 8'h00, 8'h00, 1'b0);
        sel = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", if8.busy, 1'b0);
        check("reset_done", if8.done, 1'b0);
        check("reset_sum", if8.sum, 8'h00);
        check("reset_cout", if8.cout, 1'b0);
        check("reset_sum_w1", if1.sum, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", if8.busy, 1'b0);

        // Directed vectors, both widths
        for (int i = 0; i < 12; i++) begin
            sel = vecs[i].sel;
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);
        end
        sel = 0;

        // start with new operands mid-SHIFT is ignored
        @(negedge clk);
        drive(1'b1, 8'h35, 8'h4A, 1'b0);
        cnt = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) drive(1'b0, 8'h35, 8'h4A, 1'b0);
            if (n == 3) drive(1'b1, 8'h00, 8'h00, 1'b0);
            if (n == 4) drive(1'b0, 8'h00, 8'h00, 1'b0);
            if (m_done) break;
        end
        check("midstart_latency", n, 9);
        check("midstart_sum", m_sum, 8'h7F);
        check("midstart_cout", m_cout, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_done) cnt++;
        end
        check("midstart_extra_done", cnt, 0);
        check("midstart_sum_held", m_sum, 8'h7F);

        // Reset in the 4th SHIFT cycle abandons the operation
        @(negedge clk);
        drive(1'b1, 8'h35, 8'h4A, 1'b0);
        for (n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) drive(1'b0, 8'h00, 8'h00, 1'b0);
        end
        check("pre_reset_busy", m_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midreset_busy", m_busy, 1'b0);
        check("midreset_done", m_done, 1'b0);
        check("midreset_sum", m_sum, 8'h00);
        check("midreset_cout", m_cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum[0] = 8'h00;
        prev_sum[1] = 8'h00;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_done) cnt++;
        end
        check("midreset_no_done", cnt, 0);
        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);

        // start held through DONE: back-to-back second operation
        @(negedge clk);
        drive(1'b1, 8'h01, 8'h02, 1'b0);
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) drive(1'b1, 8'h10, 8'h20, 1'b0);
            if (m_done) break;
        end
        check("b2b_first_latency", n, 9);
        check("b2b_first_sum", m_sum, 8'h03);
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("b2b_busy_after_done", m_busy, 1'b1);
                check("b2b_sum_stable", m_sum, 8'h03);
                drive(1'b0, 8'h00, 8'h00, 1'b0);
            end
            if (m_done) break;
        end
        check("b2b_second_latency", n, 9);
        check("b2b_second_sum", m_sum, 8'h30);
        check("b2b_second_cout", m_cout, 1'b0);
        prev_sum[0] = 8'h30;
        @(negedge clk);
        check("b2b_idle", m_done, 1'b0);

        // Random operations against a + b + cin
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 1000; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                if (sel) begin
                    ra = {7'b0, ra[0]};
                    rb = {7'b0, rb[0]};
                    full = 9'(ra) + 9'(rb) + 9'(rc);
                    run_op(ra, rb, rc, {7'b0, full[0]}, full[1]);
                end else begin
                    full = 9'(ra) + 9'(rb) + 9'(rc);
                    run_op(ra, rb, rc, full[7:0], full[8]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
